// File: rtl/eth_udp_hdr_inserter.sv
// eth_udp_hdr_inserter
// Store-and-forward framer: buffers one tlast-delimited payload frame, then
// emits a 42-byte Ethernet/IPv4/UDP header followed by the payload bytes.
// Total length, UDP length, IP ID and IPv4 header checksum are filled in
// for each frame. Oversize frames are swallowed and flagged.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   payload_in_tvalid/tready/tdata/tlast   8-bit AXIS payload input
//   mac_tx_tvalid/tready/tdata/tlast       8-bit AXIS frame output (registered)
//   first_byte_pulse                one-cycle pulse after header byte 0 is accepted
//   overflow_err                    one-cycle pulse after an oversize frame is dropped
module eth_udp_hdr_inserter #(
    parameter logic [47:0] DST_MAC     = 48'h02_00_00_00_00_02,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_010A,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0114,
    parameter logic [15:0] SRC_PORT    = 16'd1234,
    parameter logic [15:0] DST_PORT    = 16'd5000,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter int          MAX_PAYLOAD = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       payload_in_tvalid,
    output logic       payload_in_tready,
    input  logic [7:0] payload_in_tdata,
    input  logic       payload_in_tlast,
    output logic       mac_tx_tvalid,
    input  logic       mac_tx_tready,
    output logic [7:0] mac_tx_tdata,
    output logic       mac_tx_tlast,
    output logic       first_byte_pulse,
    output logic       overflow_err
);

    localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);
    localparam logic [10:0] HDR_LEN = 11'd42;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CSUM = 3'd2,
        S_HDR  = 3'd3,
        S_PAY  = 3'd4,
        S_DROP = 3'd5
    } state_t;

    // IPv4 header checksum over the ten header words with the checksum word at
    // zero. Ten 16-bit words fit in 20 bits; two folds absorb every carry.
    function automatic logic [15:0] ip_csum(input logic [15:0] tot_len, input logic [15:0] id);
        logic [19:0] sum;
        sum = 20'h04500 + {4'h0, tot_len} + {4'h0, id} + 20'h04000
            + {4'h0, TTL, 8'h11}
            + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
            + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
        sum = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
        sum = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
        return ~sum[15:0];
    endfunction

    state_t      state_r, state_s;
    logic [10:0] cnt_r;          // payload bytes received; holds N until the frame is sent
    logic [10:0] ptr_r;          // index of the next frame byte to load into the output register
    logic [15:0] ip_id_r;
    logic [15:0] csum_r;
    logic        in_tready_r;
    logic        out_valid_r;
    logic [7:0]  out_data_r;
    logic        out_last_r;
    logic        fbp_r;
    logic        ovf_r;
    logic        ovf_s;
    logic [7:0]  pay_mem_r [MAX_PAYLOAD];

    logic        in_fire_s;
    logic        out_fire_s;
    logic        load_s;
    logic [10:0] last_idx_s;
    logic [15:0] tot_len_s;
    logic [15:0] udp_len_s;
    logic [335:0] hdr_vec_s;
    logic [8:0]  hsel_s;
    logic [7:0]  byte_s;

    assign in_fire_s  = payload_in_tvalid & in_tready_r;
    assign out_fire_s = out_valid_r & mac_tx_tready;
    assign last_idx_s = HDR_LEN + cnt_r - 11'd1;
    assign tot_len_s  = {5'd0, cnt_r} + 16'd28;
    assign udp_len_s  = {5'd0, cnt_r} + 16'd8;
    // A new byte may enter the output register when it is empty or draining.
    assign load_s     = ((state_r == S_HDR) || (state_r == S_PAY))
                        && (ptr_r < (HDR_LEN + cnt_r))
                        && (!out_valid_r || mac_tx_tready);

    assign hdr_vec_s = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, tot_len_s, ip_id_r,
                        16'h4000, TTL, 8'h11, csum_r, SRC_IP, DST_IP,
                        SRC_PORT, DST_PORT, udp_len_s, 16'h0000};
    assign hsel_s    = 9'd335 - {ptr_r[5:0], 3'b000};

    // Select the header byte or buffered payload byte addressed by ptr_r.
    always_comb begin
        byte_s = 8'h00;
        if (ptr_r < HDR_LEN) begin
            byte_s = hdr_vec_s[hsel_s -: 8];
        end else begin
            byte_s = pay_mem_r[AW'(ptr_r - HDR_LEN)];
        end
    end

    // Next-state logic and drop-completion pulse.
    always_comb begin
        state_s = state_r;
        ovf_s   = 1'b0;
        case (state_r)
            S_IDLE, S_LOAD: begin
                if (in_fire_s) begin
                    if (cnt_r == MAX_CNT) begin
                        // this is byte MAX_PAYLOAD+1: the frame cannot fit
                        if (payload_in_tlast) begin
                            state_s = S_IDLE;
                            ovf_s   = 1'b1;
                        end else begin
                            state_s = S_DROP;
                        end
                    end else if (payload_in_tlast) begin
                        state_s = S_CSUM;
                    end else begin
                        state_s = S_LOAD;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_CSUM: state_s = S_HDR;
            S_HDR: begin
                if (load_s && (ptr_r == (HDR_LEN - 11'd1))) begin
                    state_s = S_PAY;
                end else begin
                    state_s = S_HDR;
                end
            end
            S_PAY: begin
                if (out_fire_s && out_last_r) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_PAY;
                end
            end
            S_DROP: begin
                if (in_fire_s && payload_in_tlast) begin
                    state_s = S_IDLE;
                    ovf_s   = 1'b1;
                end else begin
                    state_s = S_DROP;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Payload buffer write port; contents are don't-care until overwritten.
    always_ff @(posedge clk) begin
        if (in_fire_s && ((state_r == S_IDLE) || (state_r == S_LOAD)) && (cnt_r < MAX_CNT)) begin
            pay_mem_r[AW'(cnt_r)] <= payload_in_tdata;
        end
    end

    // Byte counter, IP ID and checksum bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 11'd0;
            ip_id_r <= 16'h0000;
            csum_r  <= 16'h0000;
        end else begin
            if (in_fire_s && ((state_r == S_IDLE) || (state_r == S_LOAD))) begin
                cnt_r <= ((state_s == S_LOAD) || (state_s == S_CSUM)) ? (cnt_r + 11'd1) : 11'd0;
            end else if (state_r == S_PAY && out_fire_s && out_last_r) begin
                cnt_r   <= 11'd0;
                ip_id_r <= ip_id_r + 16'h0001;
            end
            if (state_r == S_CSUM) begin
                csum_r <= ip_csum(tot_len_s, ip_id_r);
            end
        end
    end

    // Registered AXIS output stage; holds data/last stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= 11'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
        end else if (state_r == S_CSUM) begin
            ptr_r <= 11'd0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= byte_s;
            out_last_r  <= (ptr_r == last_idx_s);
            ptr_r       <= ptr_r + 11'd1;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
        end
    end

    // Registered status pulses and input ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_tready_r <= 1'b0;
            fbp_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            in_tready_r <= (state_s == S_IDLE) || (state_s == S_LOAD) || (state_s == S_DROP);
            // ptr_r is 1 exactly while header byte 0 sits in the output register
            fbp_r       <= (state_r == S_HDR) && out_fire_s && (ptr_r == 11'd1);
            ovf_r       <= ovf_s;
        end
    end

    assign payload_in_tready = in_tready_r;
    assign mac_tx_tvalid     = out_valid_r;
    assign mac_tx_tdata      = out_data_r;
    assign mac_tx_tlast      = out_last_r;
    assign first_byte_pulse  = fbp_r;
    assign overflow_err      = ovf_r;

endmodule

// File: doc/eth_udp_hdr_inserter.md
# eth_udp_hdr_inserter

Store-and-forward framer between the ITCH payload generator and the MAC TX AXI-Stream port. It buffers one payload frame (8-bit AXIS, tlast-delimited) and counts its length N. It then emits a 42-byte Ethernet/IPv4/UDP header followed by the N payload bytes to the MAC, with IPv4 total length, UDP length, IP ID and IP header checksum filled in per frame. It also pulses `first_byte_pulse` when the MAC accepts the first header byte, which serves as the latency-measurement timestamp.

## Interface
- `DST_MAC`, 48'h02_00_00_00_00_02, destination MAC
- `SRC_MAC`, 48'h02_00_00_00_00_01, source MAC
- `SRC_IP`, 32'hC0A8_010A, source IPv4 (192.168.1.10)
- `DST_IP`, 32'hC0A8_0114, destination IPv4 (192.168.1.20)
- `SRC_PORT`, 16'd1234, UDP source port
- `DST_PORT`, 16'd5000, UDP destination port
- `TTL`, 8'd64, IPv4 TTL
- `MAX_PAYLOAD`, 64, payload buffer depth in bytes (2..1472)
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `payload_in_tvalid`  in  1  payload byte valid
- `payload_in_tready`  out  1  block accepts payload byte
- `payload_in_tdata`  in  8  payload byte
- `payload_in_tlast`  in  1  last payload byte of frame
- `mac_tx_tvalid`  out  1  frame byte valid
- `mac_tx_tready`  in  1  MAC accepts byte
- `mac_tx_tdata`  out  8  frame byte
- `mac_tx_tlast`  out  1  last frame byte
- `first_byte_pulse`  out  1  one-cycle pulse on acceptance of header byte 0
- `overflow_err`  out  1  one-cycle pulse when an oversize frame is dropped

## Operation
- States: IDLE, LOAD, CSUM, HDR, PAY, DROP.
- IDLE/LOAD: `payload_in_tready`=1. Each accepted byte is written to `buf[cnt]` and `cnt++`. The first accepted byte moves IDLE→LOAD.
  - Accepted byte with tlast and total ≤ MAX_PAYLOAD → CSUM with N = count including that byte.
  - Byte number MAX_PAYLOAD+1 without completing the frame → DROP. Bytes are accepted and discarded until tlast. On the tlast byte, pulse `overflow_err` and return to IDLE. No output is produced.
- CSUM: one cycle with `payload_in_tready`=0. Register the IPv4 checksum, computed as the ones'-complement of the ones'-complement 16-bit sum of the ten header words with checksum=0. Carries fold twice, so a 20-bit sum is sufficient.
- HDR: send bytes 0..41. PAY: send buf[0..N-1], with `mac_tx_tlast`=1 on buf[N-1]. After that byte is accepted → IDLE, `cnt`=0, and `ip_id` increments (16-bit, wraps FFFF→0000).
- Header byte map:
  - 0–5 DST_MAC; 6–11 SRC_MAC; 12–13 0x0800
  - 14 0x45; 15 0x00; 16–17 total length 28+N; 18–19 `ip_id`; 20–21 0x4000 (DF)
  - 22 TTL; 23 0x11; 24–25 checksum; 26–29 SRC_IP; 30–33 DST_IP
  - 34–35 SRC_PORT; 36–37 DST_PORT; 38–39 UDP length 8+N; 40–41 0x0000 (no UDP checksum)
- Multi-byte fields are big-endian, MSB first.
- There is no minimum-frame padding (the MAC pads) and no FCS.
- A 1-byte payload is legal.
- `payload_in_tready`=0 in CSUM/HDR/PAY; the upstream producer stalls.

## Timing
- Reset (async assert, sync-release-safe) values:
  - All outputs 0 except `payload_in_tready`. `payload_in_tready` is 0 during reset and 1 on the first clock after release (IDLE).
  - State IDLE, `cnt`=0, `ip_id`=0.
- Reset asserted mid-frame discards the buffered/partial frame immediately. `mac_tx_tvalid` drops asynchronously.
- Last payload byte accepted at edge T → CSUM during cycle T+1 → `mac_tx_tvalid`=1 with byte 0 (DST_MAC[47:40]) from edge T+2.
- Output is an AXIS master. Once `mac_tx_tvalid`=1, `tdata`/`tlast` stay stable and tvalid stays high until `mac_tx_tready`. The byte index advances only on tvalid&tready. With `mac_tx_tready` held at 1, the frame streams back-to-back: 42+N cycles with no bubbles.
- `first_byte_pulse` is registered and is 1 the cycle after the edge where byte 0 is accepted. It fires exactly once per frame, even under backpressure.
- `overflow_err` is 1 the cycle after the dropped frame's tlast is accepted.
- Returning to IDLE after the final byte: `payload_in_tready`=1 in the next cycle. Minimum turnaround is 0 idle cycles on the input side.

## Test plan
- Defaults, 15-byte ITCH 'A' payload (41 01 02 … 08 00 64 00 00 27 10), `mac_tx_tready`=1:
  - 57 bytes out; bytes 16–17 = 00 2B; 18–19 = 00 00; 24–25 = B7 53; 38–39 = 00 17.
  - Payload bytes 42–56 match the input; tlast only on byte 56.
  - `first_byte_pulse` exactly once, two cycles after the last input byte is accepted plus one.
- Second identical frame → bytes 18–19 = 00 01, checksum = B7 52. Force `ip_id`=FFFF → the following frame has ID 00 00.
- Random `mac_tx_tready` backpressure (≈50%) on a 15-byte frame → byte stream identical to the no-backpressure case; tdata stable while tvalid&!tready; one `first_byte_pulse`.
- MAX_PAYLOAD=64:
  - Send a 65-byte frame → no `mac_tx_tvalid`, `overflow_err` pulses once after byte 65; the next 1-byte frame is framed correctly (total length 00 1D, UDP length 00 09).
  - A 64-byte frame passes unchanged.
- Deassert `rst_n` for 3 cycles during HDR byte 20 → outputs 0 at once; after release, a new 15-byte frame starts cleanly with ID 00 00 and checksum B7 53.
